cpu_datapath: RTL

- Datapath half of the VeriRISC CPU: the register/ALU side that the `control` sequencer drives.
- Consumes the controller's nine strobes (rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel) and returns opcode and zero to it.
- Holds PC, IR and AC, the ALU, the address mux and the memory write-data path.
- Sits between `control` and the 32x8 instruction/data memory.

---
 rtl/cpu_datapath_if.sv | 35 +++
 rtl/cpu_datapath.sv | 74 +++++++
 2 files changed

// File: rtl/cpu_datapath_if.sv
// Controller strobes and memory bus shared between the VeriRISC datapath and its environment.
// The datapath takes the slave modport; the control sequencer and memory side take the master modport.
interface cpu_datapath_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  logic              rd;
  logic              wr;
  logic              ld_ir;
  logic              ld_ac;
  logic              ld_pc;
  logic              inc_pc;
  logic              halt;
  logic              data_e;
  logic              sel;
  logic [DWIDTH-1:0] mem_rdata;

  logic [2:0]        opcode;
  logic              zero;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic              halted;

  modport master (
    output rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel, mem_rdata,
    input  opcode, zero, mem_addr, mem_wdata, mem_rd, mem_wr, halted
  );

  modport slave (
    input  rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel, mem_rdata,
    output opcode, zero, mem_addr, mem_wdata, mem_rd, mem_wr, halted
  );
endinterface

// File: rtl/cpu_datapath.sv
// VeriRISC datapath: PC, IR, AC, ALU, address mux and memory write-data path.
// Driven by the control sequencer's strobes; returns opcode and zero to it.
module cpu_datapath #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_,
  cpu_datapath_if.slave    bus
);

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  logic [AWIDTH-1:0] pc;
  logic [DWIDTH-1:0] ir;
  logic [DWIDTH-1:0] ac;
  logic              halted;
  logic [DWIDTH-1:0] alu_out;
  opcode_e           op;

  assign op = opcode_e'(ir[DWIDTH-1:DWIDTH-3]);

  always_comb begin
    alu_out = ac;
    unique case (op)
      OP_ADD:  alu_out = ac + bus.mem_rdata;
      OP_AND:  alu_out = ac & bus.mem_rdata;
      OP_XOR:  alu_out = ac ^ bus.mem_rdata;
      OP_LDA:  alu_out = bus.mem_rdata;
      default: alu_out = ac;
    endcase
  end

  // halted is sampled before this edge's halt, so a load coinciding with halt still lands
  always_ff @(posedge clk) begin
    if (!rst_) begin
      pc     <= '0;
      ir     <= '0;
      ac     <= '0;
      halted <= 1'b0;
    end else begin
      if (bus.halt)
        halted <= 1'b1;
      if (!halted) begin
        if (bus.ld_ir)
          ir <= bus.mem_rdata;
        if (bus.ld_ac)
          ac <= alu_out;
        if (bus.ld_pc)
          pc <= ir[AWIDTH-1:0];
        else if (bus.inc_pc)
          pc <= pc + AWIDTH'(1);
      end
    end
  end

  assign bus.opcode    = ir[DWIDTH-1:DWIDTH-3];
  assign bus.zero      = (ac == '0);
  assign bus.mem_addr  = bus.sel ? pc : ir[AWIDTH-1:0];
  assign bus.mem_wdata = bus.data_e ? alu_out : '0;
  assign bus.mem_rd    = bus.rd;
  assign bus.mem_wr    = bus.wr & ~halted;
  assign bus.halted    = halted;

endmodule
